// File: rtl/ascon_seq_ctrl.sv
// Sequencer and result buffer around the Ascon_Encryption core: drives count and
// the one-hot mode strobes, captures C/T at the end of a run and hands them out via valid/ready.
module ascon_seq_ctrl #(
    parameter int AEAD_LAST = 84,
    parameter int HASH_LAST = 99
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    output logic         busy,
    output logic [6:0]   count,
    output logic         Encryption,
    output logic         Decryption,
    output logic         Hashing,
    input  logic [255:0] core_c,
    input  logic [127:0] core_t,
    input  logic [127:0] tag_exp,
    output logic [127:0] core_tin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] c_out,
    output logic [127:0] t_out,
    output logic         auth_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_DEC  = 2'b10;
    localparam logic [1:0] MODE_HASH = 2'b11;

    state_t      state_reg;
    logic [1:0]  mode_reg;
    logic [2:0]  strobe_next;
    logic [6:0]  last_count;
    logic        tag_match;

    // strobe_next[0]=Encryption, [1]=Decryption, [2]=Hashing; one-hot by construction
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_strobe
            assign strobe_next[gi] = (mode == 2'(gi + 1));
        end
    endgenerate

    assign last_count = (mode_reg == MODE_HASH) ? 7'(HASH_LAST) : 7'(AEAD_LAST);
    assign tag_match  = (core_t == core_tin);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            mode_reg   <= 2'b00;
            busy       <= 1'b0;
            count      <= 7'd0;
            Encryption <= 1'b0;
            Decryption <= 1'b0;
            Hashing    <= 1'b0;
            core_tin   <= '0;
            out_valid  <= 1'b0;
            c_out      <= '0;
            t_out      <= '0;
            auth_ok    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && (mode != 2'b00)) begin
                        state_reg  <= RUN;
                        mode_reg   <= mode;
                        core_tin   <= tag_exp;
                        busy       <= 1'b1;
                        count      <= 7'd1;
                        Encryption <= strobe_next[0];
                        Decryption <= strobe_next[1];
                        Hashing    <= strobe_next[2];
                    end
                end
                RUN: begin
                    // The core does its final update on the same edge that leaves RUN.
                    if (count == last_count) begin
                        state_reg  <= CAPT;
                        count      <= 7'd0;
                        Encryption <= 1'b0;
                        Decryption <= 1'b0;
                        Hashing    <= 1'b0;
                    end else begin
                        count <= count + 7'd1;
                    end
                end
                CAPT: begin
                    state_reg <= DONE;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                    if (mode_reg == MODE_DEC) begin
                        c_out   <= tag_match ? core_c : '0;
                        t_out   <= core_t;
                        auth_ok <= tag_match;
                    end else if (mode_reg == MODE_HASH) begin
                        c_out   <= core_c;
                        t_out   <= '0;
                        auth_ok <= 1'b1;
                    end else begin
                        c_out   <= core_c;
                        t_out   <= core_t;
                        auth_ok <= 1'b1;
                    end
                end
                DONE: begin
                    // A start coinciding with the handshake is dropped; it must come in IDLE.
                    if (out_ready) begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
